// File: rtl/core_control_ldst.sv
// Load/store sequencer for the memory stage: single byte/half/word accesses with
// lane steering and sign extension, misalignment faults, and ascending/descending
// multi-register block transfers with final-address writeback.
module core_control_ldst #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned NREGS  = 16,
    localparam int unsigned NB      = WORD_W / 8,
    localparam int unsigned OFS_W   = $clog2(NB),
    localparam int unsigned BADDR_W = ADDR_W + OFS_W,
    localparam int unsigned REG_W   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_write,
    input  logic               op_multi,
    input  logic               op_decrement,
    input  logic [1:0]         op_size,
    input  logic               op_signed,
    input  logic [REG_W-1:0]   op_reg,
    input  logic [NREGS-1:0]   op_mask,
    input  logic [BADDR_W-1:0] base_addr,
    output logic [REG_W-1:0]   rd_index,
    input  logic [WORD_W-1:0]  rd_value,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_data_wr,
    output logic [NB-1:0]      mem_data_be,
    output logic               mem_start,
    output logic               mem_write,
    input  logic               mem_ready,
    input  logic [WORD_W-1:0]  mem_data_rd,
    output logic               wr_en,
    output logic [REG_W-1:0]   wr_index,
    output logic [WORD_W-1:0]  wr_value,
    output logic               stall,
    output logic               done,
    output logic               fault,
    output logic [BADDR_W-1:0] final_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic               multi_q, multi_d;
    logic               dec_q, dec_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [NREGS-1:0]   mask_q, mask_d;
    logic [BADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [NB-1:0]      be_q, be_d;
    logic               mem_start_q, mem_start_d;
    logic               mem_write_q, mem_write_d;
    logic               wr_en_q, wr_en_d;
    logic [REG_W-1:0]   wr_index_q, wr_index_d;
    logic [WORD_W-1:0]  wr_value_q, wr_value_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [BADDR_W-1:0] final_q, final_d;

    logic [OFS_W-1:0]   ofs_in;
    logic [REG_W-1:0]   first_reg;
    logic [REG_W-1:0]   next_reg;
    logic [BADDR_W-1:0] next_addr;

    // Lowest set bit when ascending, highest when descending
    function automatic logic [REG_W-1:0] pick(input logic [NREGS-1:0] m, input logic dn);
        logic [REG_W-1:0] r;
        r = '0;
        if (dn) begin
            for (int i = 0; i < int'(NREGS); i++) if (m[i]) r = REG_W'(i);
        end else begin
            for (int i = int'(NREGS) - 1; i >= 0; i--) if (m[i]) r = REG_W'(i);
        end
        return r;
    endfunction

    function automatic logic [NREGS-1:0] clear_bit(input logic [NREGS-1:0] m, input logic [REG_W-1:0] idx);
        return m & ~(NREGS'(1) << idx);
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [OFS_W-1:0] o);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return o[0];
            SZ_WORD: return o != '0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_be(input logic [1:0] sz, input logic [OFS_W-1:0] o);
        case (sz)
            SZ_BYTE: return NB'(1) << o;
            SZ_HALF: return NB'(3) << o;
            default: return '1;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] extract(input logic [WORD_W-1:0] d, input logic [1:0] sz,
                                                  input logic [OFS_W-1:0] o, input logic sgn);
        logic [WORD_W-1:0] sh;
        sh = d >> {o, 3'b000};
        case (sz)
            SZ_BYTE: return sgn ? WORD_W'($signed(sh[7:0]))  : WORD_W'(sh[7:0]);
            SZ_HALF: return sgn ? WORD_W'($signed(sh[15:0])) : WORD_W'(sh[15:0]);
            default: return sh;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] replicate(input logic [WORD_W-1:0] v, input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return {NB{v[7:0]}};
            SZ_HALF: return {(NB / 2){v[15:0]}};
            default: return v;
        endcase
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        multi_d     = multi_q;
        dec_d       = dec_q;
        size_d      = size_q;
        signed_d    = signed_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        cur_d       = cur_q;
        mem_addr_d  = mem_addr_q;
        be_d        = be_q;
        mem_write_d = mem_write_q;
        wr_index_d  = wr_index_q;
        wr_value_d  = wr_value_q;
        final_d     = final_q;
        mem_start_d = 1'b0;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        ofs_in      = base_addr[OFS_W-1:0];
        first_reg   = op_multi ? pick(op_mask, op_decrement) : op_reg;
        next_reg    = pick(mask_q, dec_q);
        next_addr   = dec_q ? addr_q - BADDR_W'(NB) : addr_q + BADDR_W'(NB);

        case (state_q)
            IDLE: begin
                if (start) begin
                    write_d  = op_write;
                    multi_d  = op_multi;
                    dec_d    = op_decrement;
                    signed_d = op_signed;
                    size_d   = op_multi ? SZ_WORD : op_size;
                    addr_d   = base_addr;
                    if (op_multi ? (ofs_in != '0) : misaligned(op_size, ofs_in)) begin
                        fault_d = 1'b1;
                    end else if (op_multi && op_mask == '0) begin
                        done_d  = 1'b1;
                        final_d = base_addr;
                        state_d = DONE;
                    end else begin
                        cur_d       = first_reg;
                        mask_d      = op_multi ? clear_bit(op_mask, first_reg) : '0;
                        mem_addr_d  = base_addr[BADDR_W-1:OFS_W];
                        be_d        = op_multi ? '1 : lane_be(op_size, ofs_in);
                        mem_write_d = op_write;
                        mem_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_ready) begin
                    if (!write_q) begin
                        wr_en_d    = 1'b1;
                        wr_index_d = cur_q;
                        wr_value_d = extract(mem_data_rd, size_q, addr_q[OFS_W-1:0], signed_q);
                    end
                    if (mask_q != '0) begin
                        cur_d       = next_reg;
                        mask_d      = clear_bit(mask_q, next_reg);
                        addr_d      = next_addr;
                        mem_addr_d  = next_addr[BADDR_W-1:OFS_W];
                        mem_start_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        final_d = multi_q ? next_addr : addr_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            multi_q     <= 1'b0;
            dec_q       <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            mask_q      <= '0;
            addr_q      <= '0;
            cur_q       <= '0;
            mem_addr_q  <= '0;
            be_q        <= '0;
            mem_start_q <= 1'b0;
            mem_write_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_index_q  <= '0;
            wr_value_q  <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            final_q     <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            multi_q     <= multi_d;
            dec_q       <= dec_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            cur_q       <= cur_d;
            mem_addr_q  <= mem_addr_d;
            be_q        <= be_d;
            mem_start_q <= mem_start_d;
            mem_write_q <= mem_write_d;
            wr_en_q     <= wr_en_d;
            wr_index_q  <= wr_index_d;
            wr_value_q  <= wr_value_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            final_q     <= final_d;
        end
    end

    // Store data follows the combinational register-file read while the access is in flight
    assign mem_data_wr = (write_q && (state_q == ISSUE || state_q == WAIT))
                         ? replicate(rd_value, size_q) : '0;
    assign stall       = (start && state_q == IDLE) || state_q == ISSUE || state_q == WAIT;
    assign rd_index    = cur_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_be = be_q;
    assign mem_start   = mem_start_q;
    assign mem_write   = mem_write_q;
    assign wr_en       = wr_en_q;
    assign wr_index    = wr_index_q;
    assign wr_value    = wr_value_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign final_addr  = final_q;

endmodule

// File: doc/core_control_ldst.md
Name: core_control_ldst

Overview:
- Parametrised load/store sequencer for the core's memory stage; next generation of the core's control path.
- Adds byte/halfword access with lane steering and sign extension, misalignment faults, and multi-register block transfers (ascending/descending) with final-address writeback.
- Sits between decode/register file and the memory port; stalls the pipeline while memory is in flight.

Parameters:
- WORD_W, 32: data word width in bits; multiple of 16. Derived: NB = WORD_W/8 (bytes per word), OFS_W = clog2(NB).
- ADDR_W, 30: word-pointer width on the memory port. Derived: BADDR_W = ADDR_W+OFS_W (byte address).
- NREGS, 16: register-file size. Derived: REG_W = clog2(NREGS).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; accepted only in IDLE
- op_write  in  1  1 = store, 0 = load
- op_multi  in  1  1 = block transfer over op_mask (word size forced)
- op_decrement  in  1  block direction: 1 = descending
- op_size  in  2  single access: 0 byte, 1 half, 2 word; 3 = fault
- op_signed  in  1  sign-extend narrow loads
- op_reg  in  REG_W  single-access data register
- op_mask  in  NREGS  block register list
- base_addr  in  BADDR_W  byte address
- rd_index  out  REG_W  register-file read select
- rd_value  in  WORD_W  combinational read data for rd_index
- mem_addr  out  ADDR_W  word pointer
- mem_data_wr  out  WORD_W  store data
- mem_data_be  out  NB  byte enables
- mem_start  out  1  one-cycle request pulse
- mem_write  out  1  request direction
- mem_ready  in  1  completion; earliest the cycle after mem_start
- mem_data_rd  in  WORD_W  load data, valid with mem_ready
- wr_en  out  1  register writeback strobe
- wr_index  out  REG_W  writeback register
- wr_value  out  WORD_W  writeback data
- stall  out  1  pipeline hold
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle misalignment/bad-size pulse
- final_addr  out  BADDR_W  base writeback value, valid with done

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation abandons the in-flight access; no wr_en or done follows.
- States: IDLE, ISSUE, WAIT, DONE. start in IDLE latches all op_* and base_addr; later op_* changes are ignored. start outside IDLE is ignored.
- stall = (start & IDLE) | ISSUE | WAIT. stall is low in DONE.
- ISSUE: mem_start = 1 for exactly one cycle, then go to WAIT. mem_addr, mem_write, mem_data_wr and mem_data_be are held from ISSUE until mem_ready.
- WAIT: mem_ready is ignored in ISSUE and IDLE. On mem_ready, a load registers wr_en/wr_index/wr_value for the next cycle only. Then go to ISSUE if transfers remain, else DONE.
- DONE: done = 1 and final_addr valid for one cycle, then IDLE.
- Single-access lanes, with o = base_addr[OFS_W-1:0]:
  - Byte: be = 1<<o.
  - Half: be = 3<<o; requires o even.
  - Word: be = all ones; requires o = 0.
  - Stores replicate the low byte/half of rd_value across all lanes.
  - Loads extract the lane at o, then zero- or sign-extend to WORD_W.
  - final_addr = base_addr.
- Fault: misalignment, op_size = 3, or a block base with o != 0 pulses fault in the cycle after start (in place of done). No memory access, no writeback, back to IDLE.
- Block transfer:
  - Ascending: registers are visited in increasing index; the first is at base, each next at +NB bytes.
  - Descending: registers are visited in decreasing index; the first is at base, each next at −NB bytes.
  - Address arithmetic wraps modulo 2^BADDR_W.
  - final_addr = base ± popcount(op_mask)·NB.
  - rd_index tracks the current register during ISSUE/WAIT.
  - Empty mask: no access; done in the cycle after start; final_addr = base.
- Back-to-back: a new start is accepted in the cycle DONE returns to IDLE (done-cycle start is ignored).

Test Plan:
- Word load at 0x100, mem_ready 3 cycles after mem_start, data 0xDEADBEEF -> mem_addr = 0x40, be = 4'hF; wr_en in the cycle after mem_ready with op_reg/0xDEADBEEF; done pulse; stall high throughout.
- Signed byte load at 0x103, data 0x80AA5511 -> be = 4'b1000, wr_value = 0xFFFFFF80; unsigned gives 0x00000080.
- Half store at 0x102, rd_value = 0x1234ABCD -> mem_data_wr = 0xABCDABCD, be = 4'b1100, mem_write = 1, no wr_en.
- Half load at 0x101 -> fault pulse one cycle after start, mem_start never asserts, stall drops.
- Block load, mask 0x0092, descending, base 0x200 -> r7@0x200, r4@0x1FC, r1@0x1F8; three wr_en pulses; final_addr = 0x1F4. Empty mask -> done next cycle, final_addr = 0x200.
- Assert rst during WAIT of a block store -> all outputs 0 immediately; a late mem_ready causes no activity; the next start runs normally.
